key_debounce_event: RTL



---
 rtl/key_debounce_pkg.sv | 19 +
 rtl/key_debounce_chan.sv | 146 ++++++++++++++
 rtl/key_debounce_event.sv | 39 +++
 3 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and width helpers for the key debounce front end.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        PRESSED  = 2'd2,
        DB_REL   = 2'd3
    } key_state_t;

    function automatic int db_cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles);
    endfunction

    function automatic int hold_cnt_width(input int long_cycles);
        return $clog2(long_cycles);
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-FF synchroniser, debounce FSM, hold timer and the
// registered level/pulse outputs.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8192,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic key_pressed,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DB_W   = db_cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W = hold_cnt_width(LONG_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 2);

    logic              meta_r;
    logic              key_s_r;
    key_state_t        state_r;
    key_state_t        state_s;
    logic [DB_W-1:0]   db_cnt_r;
    logic [DB_W-1:0]   db_cnt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_s;
    logic              level_r;
    logic              level_s;
    logic              press_r;
    logic              press_s;
    logic              release_r;
    logic              release_s;
    logic              long_r;
    logic              long_s;

    // Two-stage synchroniser for the asynchronous pad.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            meta_r  <= 1'b0;
            key_s_r <= 1'b0;
        end else begin
            meta_r  <= key_pressed;
            key_s_r <= meta_r;
        end
    end

    // FSM state, counters and output registers.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            db_cnt_r   <= '0;
            hold_cnt_r <= '0;
            level_r    <= 1'b0;
            press_r    <= 1'b0;
            release_r  <= 1'b0;
            long_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            db_cnt_r   <= db_cnt_s;
            hold_cnt_r <= hold_cnt_s;
            level_r    <= level_s;
            press_r    <= press_s;
            release_r  <= release_s;
            long_r     <= long_s;
        end
    end

    // Next-state logic; pulses are decided on the transition edge so they
    // appear in the first cycle of the new state.
    always_comb begin
        state_s    = state_r;
        db_cnt_s   = db_cnt_r;
        hold_cnt_s = hold_cnt_r;
        level_s    = level_r;
        press_s    = 1'b0;
        release_s  = 1'b0;
        long_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (key_s_r) begin
                    state_s  = DB_PRESS;
                    db_cnt_s = '0;
                end else begin
                    state_s  = IDLE;
                end
            end
            DB_PRESS: begin
                if (!key_s_r) begin
                    state_s  = IDLE;
                    db_cnt_s = '0;
                end else if (db_cnt_r == DB_LAST) begin
                    state_s    = PRESSED;
                    press_s    = 1'b1;
                    level_s    = 1'b1;
                    hold_cnt_s = '0;
                end else begin
                    db_cnt_s = db_cnt_r + DB_W'(1);
                end
            end
            PRESSED: begin
                // Saturating hold timer keeps long_pulse to one per press.
                if (hold_cnt_r < HOLD_LAST) begin
                    hold_cnt_s = hold_cnt_r + HOLD_W'(1);
                    long_s     = (hold_cnt_r == HOLD_PRE);
                end else begin
                    hold_cnt_s = hold_cnt_r;
                end
                if (!key_s_r) begin
                    state_s  = DB_REL;
                    db_cnt_s = '0;
                end else begin
                    state_s  = PRESSED;
                end
            end
            DB_REL: begin
                if (key_s_r) begin
                    state_s = PRESSED;
                end else if (db_cnt_r == DB_LAST) begin
                    state_s    = IDLE;
                    release_s  = 1'b1;
                    level_s    = 1'b0;
                    hold_cnt_s = '0;
                end else begin
                    db_cnt_s = db_cnt_r + DB_W'(1);
                end
            end
            default: begin
                state_s    = IDLE;
                db_cnt_s   = '0;
                hold_cnt_s = '0;
                level_s    = 1'b0;
            end
        endcase
    end

    assign key_level     = level_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign long_pulse    = long_r;

endmodule

// File: rtl/key_debounce_event.sv
// Multi-channel push-button front end: polarity fix plus one independent
// debounce channel per key.
module key_debounce_event
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 8192,
    parameter int LONG_CYCLES     = 50000000,
    parameter bit KEY_ACTIVE_HIGH = 1'b1
) (
    input  logic                clk_50m,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse
);

    logic [NUM_KEYS-1:0] pressed_s;

    assign pressed_s = key_in ~^ {NUM_KEYS{KEY_ACTIVE_HIGH}};

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_chan (
            .clk_50m      (clk_50m),
            .rst_n        (rst_n),
            .key_pressed  (pressed_s[g]),
            .key_level    (key_level[g]),
            .press_pulse  (press_pulse[g]),
            .release_pulse(release_pulse[g]),
            .long_pulse   (long_pulse[g])
        );
    end

endmodule
